ysyx_22041412_trap_ctrl: RTL and testbench

- Sequencer in front of the machine-mode CSR file.
- Accepts one request at a time from EXU: a Zicsr read-modify-write, ECALL or MRET. With IRQ support compiled in, it also accepts a machine timer interrupt.
- Splits each request into single-register CSR accesses over a req/ack port, and drives a PC redirect for trap entry and return.
- Sits between EXU and the CSR file. It is the only master of the CSR port.

---
 rtl/ysyx_22041412_trap_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_ysyx_22041412_trap_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_trap_ctrl.sv
// ysyx_22041412_trap_ctrl
// Sequencer in front of the machine-mode CSR file. Takes one request at a
// time from EXU (Zicsr read-modify-write, ECALL, MRET; plus a machine timer
// interrupt when YSYX_22041412_TRAP_IRQ_EN is defined), breaks it into
// single-register CSR accesses over a req/ack port and drives the PC
// redirect for trap entry and return.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   exu_valid_i/op/func3/addr/wdata/pc   EXU request (held until exu_ready_o)
//   exu_ready_o, exu_rdata_o             completion pulse + old CSR value
//   irq_i, irq_pc_i                      timer interrupt level + PC for mepc
//   csr_req_o/we/addr/wdata, csr_ack_i, csr_rdata_i   CSR access port
//   redirect_valid_o, redirect_pc_o      fetch restart pulse + target
//   busy_o                               sequence in progress
//
// Build option: define YSYX_22041412_TRAP_IRQ_EN to enable interrupt entry.
//
// state     | meaning
// IDLE      | waiting for a request
// C_RD      | Zicsr: read old value
// C_WR      | Zicsr: write new value
// T_EPC     | trap entry: write mepc
// T_CAUSE   | trap entry: write mcause
// T_ST_RD   | trap entry: read mstatus
// T_ST_WR   | trap entry: write mstatus (MPIE<-MIE, MIE<-0, MPP<-11)
// T_VEC     | trap entry: read mtvec for the target
// R_EPC     | MRET: read mepc for the target
// R_ST_RD   | MRET: read mstatus
// R_ST_WR   | MRET: write mstatus (MIE<-MPIE, MPIE<-1, MPP<-11)
// DONE      | pulse ready and/or redirect
module ysyx_22041412_trap_ctrl #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] CAUSE_ECALL = 64'd11,
  parameter logic [XLEN-1:0] CAUSE_MTI   = 64'h8000_0000_0000_0007
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exu_valid_i,
  input  logic [1:0]      exu_op_i,
  input  logic [2:0]      exu_func3_i,
  input  logic [2:0]      exu_addr_i,
  input  logic [XLEN-1:0] exu_wdata_i,
  input  logic [XLEN-1:0] exu_pc_i,
  output logic            exu_ready_o,
  output logic [XLEN-1:0] exu_rdata_o,
  input  logic            irq_i,
  input  logic [XLEN-1:0] irq_pc_i,
  output logic            csr_req_o,
  output logic            csr_we_o,
  output logic [2:0]      csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic            csr_ack_i,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_C_RD, S_C_WR, S_T_EPC, S_T_CAUSE, S_T_ST_RD, S_T_ST_WR,
    S_T_VEC, S_R_EPC, S_R_ST_RD, S_R_ST_WR, S_DONE
  } state_t;

  typedef enum logic [1:0] {K_CSR, K_ECALL, K_MRET, K_IRQ} kind_t;

  localparam logic [2:0] A_MSTATUS = 3'd2;
  localparam logic [2:0] A_MTVEC   = 3'd3;
  localparam logic [2:0] A_MEPC    = 3'd4;
  localparam logic [2:0] A_MCAUSE  = 3'd5;

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [1:0]        func_q, func_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [2:0]        caddr_q, caddr_d;
  logic [XLEN-1:0]   cwdata_q, cwdata_d;
  logic              mie_q, mie_d;
  logic              mpie_q, mpie_d;

  logic              acc_done;
  logic [XLEN-1:0]   csr_new;
  logic [XLEN-1:0]   st_trap;
  logic [XLEN-1:0]   st_mret;

  // func3[2] only selects rs1 vs uimm, which EXU has already resolved.
`ifdef YSYX_22041412_TRAP_IRQ_EN
  logic unused_in;
  assign unused_in = exu_func3_i[2];
`else
  logic unused_in;
  assign unused_in = ^{exu_func3_i[2], irq_i, irq_pc_i, CAUSE_MTI};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      kind_q   <= K_CSR;
      func_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      target_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      caddr_q  <= '0;
      cwdata_q <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      func_q   <= func_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      target_q <= target_d;
      req_q    <= req_d;
      we_q     <= we_d;
      caddr_q  <= caddr_d;
      cwdata_q <= cwdata_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    func_d   = func_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    target_d = target_q;
    req_d    = req_q;
    we_d     = we_q;
    caddr_d  = caddr_q;
    cwdata_d = cwdata_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;

    acc_done = req_q && csr_ack_i;

    case (func_q)
      2'b10:   csr_new = csr_rdata_i | wdata_q;
      2'b11:   csr_new = csr_rdata_i & ~wdata_q;
      default: csr_new = wdata_q;
    endcase

    st_trap        = csr_rdata_i;
    st_trap[7]     = csr_rdata_i[3];
    st_trap[3]     = 1'b0;
    st_trap[12:11] = 2'b11;

    st_mret        = csr_rdata_i;
    st_mret[3]     = csr_rdata_i[7];
    st_mret[7]     = 1'b1;
    st_mret[12:11] = 2'b11;

    case (state_q)
      S_IDLE: begin
`ifdef YSYX_22041412_TRAP_IRQ_EN
        if (irq_i && mie_q) begin
          kind_d   = K_IRQ;
          rdata_d  = '0;
          state_d  = S_T_EPC;
          req_d    = 1'b1;
          we_d     = 1'b1;
          caddr_d  = A_MEPC;
          cwdata_d = irq_pc_i;
        end else
`endif
        if (exu_valid_i) begin
          rdata_d = '0;
          case (exu_op_i)
            2'b01: begin
              kind_d   = K_ECALL;
              state_d  = S_T_EPC;
              req_d    = 1'b1;
              we_d     = 1'b1;
              caddr_d  = A_MEPC;
              cwdata_d = exu_pc_i;
            end
            2'b10: begin
              kind_d  = K_MRET;
              state_d = S_R_EPC;
              req_d   = 1'b1;
              we_d    = 1'b0;
              caddr_d = A_MEPC;
            end
            default: begin
              kind_d  = K_CSR;
              func_d  = exu_func3_i[1:0];
              wdata_d = exu_wdata_i;
              caddr_d = exu_addr_i;
              we_d    = 1'b0;
              if (exu_func3_i[1:0] == 2'b00) begin
                state_d = S_DONE;
              end else begin
                state_d = S_C_RD;
                req_d   = 1'b1;
              end
            end
          endcase
        end
      end
      S_C_RD: if (acc_done) begin
        rdata_d = csr_rdata_i;
        // set/clear with a zero mask must not write
        if (func_q[1] && (wdata_q == '0)) begin
          state_d = S_DONE;
          req_d   = 1'b0;
        end else begin
          state_d  = S_C_WR;
          we_d     = 1'b1;
          cwdata_d = csr_new;
        end
      end
      S_C_WR: if (acc_done) begin
        state_d = S_DONE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        if (caddr_q == A_MSTATUS) begin
          mie_d  = cwdata_q[3];
          mpie_d = cwdata_q[7];
        end
      end
      S_T_EPC: if (acc_done) begin
        state_d = S_T_CAUSE;
        caddr_d = A_MCAUSE;
`ifdef YSYX_22041412_TRAP_IRQ_EN
        cwdata_d = (kind_q == K_IRQ) ? CAUSE_MTI : CAUSE_ECALL;
`else
        cwdata_d = CAUSE_ECALL;
`endif
      end
      S_T_CAUSE: if (acc_done) begin
        state_d = S_T_ST_RD;
        we_d    = 1'b0;
        caddr_d = A_MSTATUS;
      end
      S_T_ST_RD: if (acc_done) begin
        state_d  = S_T_ST_WR;
        we_d     = 1'b1;
        cwdata_d = st_trap;
      end
      S_T_ST_WR: if (acc_done) begin
        state_d = S_T_VEC;
        we_d    = 1'b0;
        caddr_d = A_MTVEC;
        mie_d   = cwdata_q[3];
        mpie_d  = cwdata_q[7];
      end
      S_T_VEC: if (acc_done) begin
        state_d  = S_DONE;
        req_d    = 1'b0;
        target_d = {csr_rdata_i[XLEN-1:2], 2'b00};
      end
      S_R_EPC: if (acc_done) begin
        state_d  = S_R_ST_RD;
        caddr_d  = A_MSTATUS;
        target_d = csr_rdata_i;
      end
      S_R_ST_RD: if (acc_done) begin
        state_d  = S_R_ST_WR;
        we_d     = 1'b1;
        cwdata_d = st_mret;
      end
      S_R_ST_WR: if (acc_done) begin
        state_d = S_DONE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        mie_d   = cwdata_q[3];
        mpie_d  = cwdata_q[7];
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign csr_req_o        = req_q;
  assign csr_we_o         = we_q;
  assign csr_addr_o       = caddr_q;
  assign csr_wdata_o      = cwdata_q;
  assign exu_rdata_o      = rdata_q;
  assign redirect_pc_o    = target_q;
  assign busy_o           = (state_q != S_IDLE);
  assign exu_ready_o      = (state_q == S_DONE) && (kind_q != K_IRQ);
  assign redirect_valid_o = (state_q == S_DONE) && (kind_q != K_CSR);

`ifndef SYNTHESIS
  // An EXU-originated sequence relies on the request staying valid.
  always @(posedge clk) begin
    if (rst_n && busy_o && (state_q != S_DONE) && (kind_q != K_IRQ)) begin
      assert (exu_valid_i)
        else $error("exu_valid_i dropped before exu_ready_o");
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041412_trap_ctrl.sv
module tb_ysyx_22041412_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_valid_i;
  logic [1:0]  exu_op_i;
  logic [2:0]  exu_func3_i;
  logic [2:0]  exu_addr_i;
  logic [63:0] exu_wdata_i;
  logic [63:0] exu_pc_i;
  logic        exu_ready_o;
  logic [63:0] exu_rdata_o;
  logic        irq_i;
  logic [63:0] irq_pc_i;
  logic        csr_req_o;
  logic        csr_we_o;
  logic [2:0]  csr_addr_o;
  logic [63:0] csr_wdata_o;
  logic        csr_ack_i;
  logic [63:0] csr_rdata_i;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        busy_o;

  ysyx_22041412_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid_i(exu_valid_i), .exu_op_i(exu_op_i), .exu_func3_i(exu_func3_i),
    .exu_addr_i(exu_addr_i), .exu_wdata_i(exu_wdata_i), .exu_pc_i(exu_pc_i),
    .exu_ready_o(exu_ready_o), .exu_rdata_o(exu_rdata_o),
    .irq_i(irq_i), .irq_pc_i(irq_pc_i),
    .csr_req_o(csr_req_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o), .csr_ack_i(csr_ack_i), .csr_rdata_i(csr_rdata_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // CSR file model with a programmable number of wait cycles per access
  logic [63:0] csr_mem [8];
  logic [2:0]  wr_addr [64];
  logic [63:0] wr_data [64];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          wait_cnt;
  int          ack_wait = 0;
  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [63:0] pl_data = '0;

  always_comb begin
    csr_ack_i   = csr_req_o && (wait_cnt >= ack_wait);
    csr_rdata_i = csr_mem[csr_addr_o];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
    end else begin
      if (pl_en) csr_mem[pl_addr] <= pl_data;
      if (csr_req_o && csr_ack_i) begin
        wait_cnt <= 0;
        if (csr_we_o) begin
          csr_mem[csr_addr_o] <= csr_wdata_o;
          wr_addr[wr_cnt]     <= csr_addr_o;
          wr_data[wr_cnt]     <= csr_wdata_o;
          wr_cnt              <= wr_cnt + 1;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end else if (csr_req_o) begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          lat;
  logic        r_ready, r_redir;
  logic [63:0] r_rdata, r_pc;
  int          wb, rb;
  logic [63:0] ms_keep;
  logic        found;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_csr(input logic [2:0] a, input logic [63:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  // Waits for ready or redirect; lat counts edges starting at the accepting one.
  task automatic wait_evt();
    lat = -1;
    r_ready = 1'b0; r_redir = 1'b0; r_rdata = '0; r_pc = '0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (exu_ready_o || redirect_valid_o) begin
        lat     = n;
        r_ready = exu_ready_o;
        r_redir = redirect_valid_o;
        r_rdata = exu_rdata_o;
        r_pc    = redirect_pc_o;
        if (exu_ready_o) exu_valid_i = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_req(input logic [1:0] op, input logic [2:0] f3, input logic [2:0] a,
                         input logic [63:0] wd, input logic [63:0] pc);
    exu_op_i    = op;
    exu_func3_i = f3;
    exu_addr_i  = a;
    exu_wdata_i = wd;
    exu_pc_i    = pc;
    exu_valid_i = 1'b1;
    wb = wr_cnt;
    rb = rd_cnt;
    wait_evt();
  endtask

  task automatic to_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    exu_valid_i = 1'b0; exu_op_i = '0; exu_func3_i = '0; exu_addr_i = '0;
    exu_wdata_i = '0; exu_pc_i = '0; irq_i = 1'b0; irq_pc_i = '0;
    #1;
    check("rst_req", 64'(csr_req_o), 64'd0);
    check("rst_we", 64'(csr_we_o), 64'd0);
    check("rst_addr", 64'(csr_addr_o), 64'd0);
    check("rst_wdata", csr_wdata_o, 64'd0);
    check("rst_ready", 64'(exu_ready_o), 64'd0);
    check("rst_rdata", exu_rdata_o, 64'd0);
    check("rst_redir", 64'(redirect_valid_o), 64'd0);
    check("rst_rpc", redirect_pc_o, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    set_csr(3'd2, 64'h0000_000a_0000_1800);
    set_csr(3'd3, 64'h0000_0000_8000_0101);

    // csrrs mstatus, 0x8 with zero-wait ack
    ack_wait = 0;
    run_req(2'b00, 3'b010, 3'd2, 64'h8, 64'h0);
    check("csrrs_lat", 64'(lat), 64'd3);
    check("csrrs_rdata", r_rdata, 64'h0000_000a_0000_1800);
    check("csrrs_nwr", 64'(wr_cnt - wb), 64'd1);
    check("csrrs_waddr", 64'(wr_addr[wb]), 64'd2);
    check("csrrs_wdata", wr_data[wb], 64'h0000_000a_0000_1808);
    check("csrrs_redir", 64'(r_redir), 64'd0);
    to_idle();
    check("csrrs_idle", 64'(busy_o), 64'd0);

    // csrrc with zero mask: read only
    run_req(2'b00, 3'b011, 3'd2, 64'h0, 64'h0);
    check("csrrc0_lat", 64'(lat), 64'd2);
    check("csrrc0_nwr", 64'(wr_cnt - wb), 64'd0);
    check("csrrc0_nrd", 64'(rd_cnt - rb), 64'd1);
    check("csrrc0_rdata", r_rdata, 64'h0000_000a_0000_1808);
    to_idle();

    // func3 00: no CSR access at all; reserved op 11 behaves as a CSR insn
    run_req(2'b11, 3'b000, 3'd3, 64'h5, 64'h0);
    check("f3zero_lat", 64'(lat), 64'd1);
    check("f3zero_rdata", r_rdata, 64'h0);
    check("f3zero_nacc", 64'((wr_cnt - wb) + (rd_cnt - rb)), 64'd0);
    to_idle();

    // ECALL with two wait cycles per access
    ack_wait = 2;
    run_req(2'b01, 3'b000, 3'd0, 64'h0, 64'h0000_0000_8000_0010);
    check("ecall_lat", 64'(lat), 64'd16);
    check("ecall_ready", 64'(r_ready), 64'd1);
    check("ecall_redir", 64'(r_redir), 64'd1);
    check("ecall_rpc", r_pc, 64'h0000_0000_8000_0100);
    check("ecall_nwr", 64'(wr_cnt - wb), 64'd3);
    check("ecall_w0a", 64'(wr_addr[wb]), 64'd4);
    check("ecall_w0d", wr_data[wb], 64'h0000_0000_8000_0010);
    check("ecall_w1a", 64'(wr_addr[wb+1]), 64'd5);
    check("ecall_w1d", wr_data[wb+1], 64'd11);
    check("ecall_w2a", 64'(wr_addr[wb+2]), 64'd2);
    check("ecall_w2d", wr_data[wb+2], 64'h0000_000a_0000_1880);
    to_idle();

    // MRET with software-adjusted mepc
    ack_wait = 0;
    set_csr(3'd4, 64'h0000_0000_8000_0014);
    run_req(2'b10, 3'b000, 3'd0, 64'h0, 64'h0);
    check("mret_lat", 64'(lat), 64'd4);
    check("mret_ready", 64'(r_ready), 64'd1);
    check("mret_redir", 64'(r_redir), 64'd1);
    check("mret_rpc", r_pc, 64'h0000_0000_8000_0014);
    check("mret_nwr", 64'(wr_cnt - wb), 64'd1);
    check("mret_wd", wr_data[wb], 64'h0000_000a_0000_1888);
    to_idle();

    // irq_i and a csrrs mcause,x0 arrive together with MIE set
    irq_pc_i = 64'h0000_0000_8000_0200;
    irq_i    = 1'b1;
    run_req(2'b00, 3'b010, 3'd5, 64'h0, 64'h0);
`ifdef YSYX_22041412_TRAP_IRQ_EN
    irq_i = 1'b0;
    check("irq_lat", 64'(lat), 64'd6);
    check("irq_ready", 64'(r_ready), 64'd0);
    check("irq_redir", 64'(r_redir), 64'd1);
    check("irq_rpc", r_pc, 64'h0000_0000_8000_0100);
    check("irq_nwr", 64'(wr_cnt - wb), 64'd3);
    check("irq_mepc", wr_data[wb], 64'h0000_0000_8000_0200);
    check("irq_mcause", wr_data[wb+1], 64'h8000_0000_0000_0007);
    check("irq_mstatus", wr_data[wb+2], 64'h0000_000a_0000_1880);
    wait_evt();
    check("irq_exu_lat", 64'(lat), 64'd3);
    check("irq_exu_ready", 64'(r_ready), 64'd1);
    check("irq_exu_rdata", r_rdata, 64'h8000_0000_0000_0007);
`else
    irq_i = 1'b0;
    check("noirq_lat", 64'(lat), 64'd2);
    check("noirq_ready", 64'(r_ready), 64'd1);
    check("noirq_redir", 64'(r_redir), 64'd0);
    check("noirq_rdata", r_rdata, 64'd11);
    check("noirq_nwr", 64'(wr_cnt - wb), 64'd0);
`endif
    to_idle();

    // reset in the middle of the trap-entry mstatus write
    ack_wait = 2;
    exu_op_i = 2'b01; exu_pc_i = 64'h0000_0000_8000_0040; exu_valid_i = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (csr_req_o && csr_we_o && (csr_addr_o == 3'd2)) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reach", 64'(found), 64'd1);
    wb = wr_cnt;
    ms_keep = csr_mem[2];
    @(posedge clk); #1;
    rst_n = 1'b0;
    exu_valid_i = 1'b0;
    #1;
    check("abort_req", 64'(csr_req_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_redir", 64'(redirect_valid_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_nwr", 64'(wr_cnt - wb), 64'd0);
    check("abort_mstatus", csr_mem[2], ms_keep);
    check("abort_idle", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
